// File: rtl/fft_pkg.sv
// Shared constants and types for the 32-point pipelined FFT.
// Every FFT stage imports this package.
`timescale 1ns/1ps
package fft_pkg;

   localparam int FFT_N     = 32;
   localparam int FFT_LANES = 16;
   localparam int FFT_IN_W  = 12;

   typedef struct packed {
      logic signed [FFT_IN_W-1:0] re;
      logic signed [FFT_IN_W-1:0] im;
   } cplx_t;

   typedef cplx_t [0:FFT_LANES-1] lane_vec_t;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_BEAT0,
      RD_BEAT1
   } rd_state_t;

endpackage

// File: rtl/fft_pingpong_bank.sv
// One frame of packer storage: 2 beats x NUM lanes with a full flag.
// Writes go to a linear sample index and reads are a whole beat at a time.
`timescale 1ns/1ps
module fft_pingpong_bank
   import fft_pkg::*;
#(
   parameter int WIDTH = FFT_IN_W,
   parameter int NUM   = FFT_LANES,
   localparam int IW   = $clog2(2*NUM)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    wr_en,
   input  logic [IW-1:0]           wr_idx,
   input  logic signed [WIDTH-1:0] wr_re,
   input  logic signed [WIDTH-1:0] wr_im,
   input  logic                    set_full,
   input  logic                    free,
   output logic                    full,
   input  logic                    rd_beat,
   output logic signed [WIDTH-1:0] rd_re [0:NUM-1],
   output logic signed [WIDTH-1:0] rd_im [0:NUM-1]
);

   logic signed [WIDTH-1:0] mem_re [0:1][0:NUM-1];
   logic signed [WIDTH-1:0] mem_im [0:1][0:NUM-1];

   // Storage needs no reset: contents are only visible once full is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_re[wr_idx[IW-1]][wr_idx[IW-2:0]] <= wr_re;
         mem_im[wr_idx[IW-1]][wr_idx[IW-2:0]] <= wr_im;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         full <= 1'b0;
      else if (set_full)
         full <= 1'b1;
      else if (free)
         full <= 1'b0;
   end

   always_comb begin
      for (int i = 0; i < NUM; i++) begin
         rd_re[i] = mem_re[rd_beat][i];
         rd_im[i] = mem_im[rd_beat][i];
      end
   end

endmodule

// File: rtl/fft_input_packer.sv
// Serial-to-vector front end of the 32-point FFT: ping-pong packs each
// frame into two contiguous NUM-lane beats for the first butterfly stage.
`timescale 1ns/1ps
module fft_input_packer
   import fft_pkg::*;
#(
   parameter int WIDTH = FFT_IN_W,
   parameter int NUM   = FFT_LANES,
   parameter int DATA  = FFT_N
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic signed [WIDTH-1:0] s_re,
   input  logic signed [WIDTH-1:0] s_im,
   input  logic                    s_last,
   output logic signed [WIDTH-1:0] dout_re [0:NUM-1],
   output logic signed [WIDTH-1:0] dout_im [0:NUM-1],
   output logic                    valid_out,
   output logic                    frame_err
);

   localparam int IW = $clog2(DATA);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA-1);

   logic [IW-1:0] idx;
   logic          wb;
   logic          rb;
   rd_state_t     state;

   logic          acc;
   logic          done;
   logic          start;
   logic          wb_nxt;
   logic          rd_beat;
   logic [1:0]    full;
   logic [1:0]    full_nxt;
   logic [1:0]    wr_en;
   logic [1:0]    set_full;
   logic [1:0]    free;

   logic signed [WIDTH-1:0] rd_re [0:1][0:NUM-1];
   logic signed [WIDTH-1:0] rd_im [0:1][0:NUM-1];

   assign acc     = s_valid && s_ready;
   assign done    = acc && (idx == LAST_IDX);
   assign start   = full[rb];
   assign wb_nxt  = done ? ~wb : wb;
   assign rd_beat = (state == RD_BEAT0);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      assign wr_en[b]    = acc && (wb == 1'(b));
      assign set_full[b] = done && (wb == 1'(b));
      assign free[b]     = rd_beat && (rb == 1'(b));
      // Post-free view, so a bank drained this cycle is writable next.
      assign full_nxt[b] = (full[b] & ~free[b]) | set_full[b];

      fft_pingpong_bank #(
         .WIDTH (WIDTH),
         .NUM   (NUM)
      ) u_bank (
         .clk      (clk),
         .rstn     (rstn),
         .wr_en    (wr_en[b]),
         .wr_idx   (idx),
         .wr_re    (s_re),
         .wr_im    (s_im),
         .set_full (set_full[b]),
         .free     (free[b]),
         .full     (full[b]),
         .rd_beat  (rd_beat),
         .rd_re    (rd_re[b]),
         .rd_im    (rd_im[b])
      );
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx       <= '0;
         wb        <= 1'b0;
         frame_err <= 1'b0;
         s_ready   <= 1'b1;
      end else begin
         frame_err <= 1'b0;
         s_ready   <= ~full_nxt[wb_nxt];
         if (acc) begin
            if (idx == LAST_IDX) begin
               idx       <= '0;
               wb        <= ~wb;
               frame_err <= ~s_last;
            end else if (s_last) begin
               idx       <= '0;
               frame_err <= 1'b1;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

   // State names the beat currently on the outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= RD_IDLE;
         rb        <= 1'b0;
         valid_out <= 1'b0;
         for (int i = 0; i < NUM; i++) begin
            dout_re[i] <= '0;
            dout_im[i] <= '0;
         end
      end else begin
         unique case (state)
            RD_BEAT0: begin
               state     <= RD_BEAT1;
               valid_out <= 1'b1;
               rb        <= ~rb;
               for (int i = 0; i < NUM; i++) begin
                  dout_re[i] <= rd_re[rb][i];
                  dout_im[i] <= rd_im[rb][i];
               end
            end
            default: begin
               if (start) begin
                  state     <= RD_BEAT0;
                  valid_out <= 1'b1;
                  for (int i = 0; i < NUM; i++) begin
                     dout_re[i] <= rd_re[rb][i];
                     dout_im[i] <= rd_im[rb][i];
                  end
               end else begin
                  state     <= RD_IDLE;
                  valid_out <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_input_packer.sv
// Directed bench for fft_input_packer with a beat scoreboard
// filled by a reference model of the framing rules.
`timescale 1ns/1ps
module tb_fft_input_packer;

   localparam int W  = 12;
   localparam int L  = 16;
   localparam int BW = 2*L*W;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic s_valid = 1'b0;
   logic s_ready;
   logic signed [W-1:0] s_re = '0;
   logic signed [W-1:0] s_im = '0;
   logic s_last = 1'b0;
   logic signed [W-1:0] dout_re [0:L-1];
   logic signed [W-1:0] dout_im [0:L-1];
   logic valid_out;
   logic frame_err;

   fft_input_packer dut (
      .clk       (clk),
      .rstn      (rstn),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_re      (s_re),
      .s_im      (s_im),
      .s_last    (s_last),
      .dout_re   (dout_re),
      .dout_im   (dout_im),
      .valid_out (valid_out),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;
   int err_cnt = 0;
   int exp_err = 0;
   int beats = 0;
   int run = 0;
   int last_run = 0;
   int stalls = 0;
   int m_idx = 0;
   logic signed [W-1:0] cur_re [0:31];
   logic signed [W-1:0] cur_im [0:31];
   logic [BW-1:0] sb [$];

   function automatic logic [BW-1:0] pack_out();
      logic [BW-1:0] v;
      for (int i = 0; i < L; i++)
         v[i*2*W +: 2*W] = {dout_re[i], dout_im[i]};
      return v;
   endfunction

   function automatic logic [BW-1:0] model_beat(input int b);
      logic [BW-1:0] v;
      for (int i = 0; i < L; i++)
         v[i*2*W +: 2*W] = {cur_re[b*L+i], cur_im[b*L+i]};
      return v;
   endfunction

   task automatic chk(input string tag, input logic [BW-1:0] got,
                      input logic [BW-1:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int re, input int im, input bit last);
      int w;
      w = 0;
      s_valid = 1'b1;
      s_re = re[W-1:0];
      s_im = im[W-1:0];
      s_last = last;
      while (!s_ready && w < 200) begin
         step();
         w++;
         stalls++;
      end
      if (!s_ready) begin
         chk("ready_timeout", {31'd0, s_ready}, 1);
         s_valid = 1'b0;
         return;
      end
      step();
      s_valid = 1'b0;
      s_last = 1'b0;
      cur_re[m_idx] = re[W-1:0];
      cur_im[m_idx] = im[W-1:0];
      if (m_idx == 31) begin
         sb.push_back(model_beat(0));
         sb.push_back(model_beat(1));
         if (!last) exp_err++;
         m_idx = 0;
      end else if (last) begin
         exp_err++;
         m_idx = 0;
      end else begin
         m_idx++;
      end
   endtask

   task automatic send_frame(input int base, input int n, input bit last_ok);
      for (int k = 0; k < n; k++)
         send(base + k, -(base + k), (k == n-1) && last_ok);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || valid_out) && n < 50) begin
         step();
         n++;
      end
      chk("drain", sb.size(), 0);
      repeat (2) step();
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (frame_err) err_cnt++;
         if (valid_out) begin
            logic [BW-1:0] got;
            logic [BW-1:0] exp;
            got = pack_out();
            run++;
            beats++;
            compared++;
            assert (sb.size() > 0) else begin
               mismatched++;
               $error("FAIL beat_unexpected: observed %0h expected none", got);
            end
            if (sb.size() > 0) begin
               exp = sb.pop_front();
               assert (got === exp) else begin
                  mismatched++;
                  $error("FAIL beat%0d: observed %0h expected %0h",
                         beats, got, exp);
               end
            end
         end else if (run != 0) begin
            last_run = run;
            run = 0;
         end
      end
   end

   int b0;

   initial begin
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      step();
      chk("rst_valid", valid_out, 0);
      chk("rst_err", frame_err, 0);
      chk("rst_ready", s_ready, 1);
      chk("rst_dout", pack_out(), 0);

      // Ramp frame with latency checks
      send_frame(0, 32, 1'b1);
      chk("lat_t0", valid_out, 0);
      step();
      chk("lat_t1", valid_out, 1);
      step();
      chk("lat_t2", valid_out, 1);
      step();
      chk("lat_t3", valid_out, 0);
      drain();
      chk("ramp_run", last_run, 2);
      chk("ramp_err", err_cnt, exp_err);
      chk("ramp_beats", beats, 2);

      // Three continuous frames
      stalls = 0;
      b0 = beats;
      for (int f = 0; f < 3; f++)
         send_frame(100*f, 32, 1'b1);
      drain();
      chk("stream_stalls", stalls, 0);
      chk("stream_beats", beats - b0, 6);
      chk("stream_err", err_cnt, exp_err);

      // Backpressure: hold the reader so both banks fill
      force dut.start = 1'b0;
      b0 = beats;
      send_frame(300, 32, 1'b1);
      send_frame(400, 32, 1'b1);
      chk("bp_ready0", s_ready, 0);
      s_valid = 1'b1;
      s_re = 12'sd500;
      s_im = -12'sd500;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("bp_hold_ready", s_ready, 0);
      end
      chk("bp_no_beats", beats - b0, 0);
      release dut.start;
      send(500, -500, 1'b0);
      repeat (3) step();
      chk("bp_run", last_run, 4);
      chk("bp_beats", beats - b0, 4);
      for (int k = 1; k < 32; k++)
         send(500 + k, -(500 + k), k == 31);
      drain();
      chk("bp_tail_beats", beats - b0, 6);
      chk("bp_err", err_cnt, exp_err);

      // Early s_last discards the partial frame
      b0 = beats;
      send_frame(600, 10, 1'b1);
      repeat (4) step();
      chk("early_err", err_cnt, exp_err);
      chk("early_beats", beats - b0, 0);
      send_frame(700, 32, 1'b1);
      drain();
      chk("early_next_beats", beats - b0, 2);

      // Missing s_last on the final sample
      b0 = beats;
      send_frame(800, 32, 1'b0);
      drain();
      chk("nolast_err", err_cnt, exp_err);
      chk("nolast_beats", beats - b0, 2);

      // Reset in the middle of a frame
      send_frame(900, 20, 1'b0);
      rstn = 1'b0;
      m_idx = 0;
      #1;
      chk("mid_rst_dout", pack_out(), 0);
      chk("mid_rst_valid", valid_out, 0);
      chk("mid_rst_ready", s_ready, 1);
      chk("mid_rst_err", frame_err, 0);
      repeat (2) step();
      rstn = 1'b1;
      step();
      b0 = beats;
      send_frame(1000, 32, 1'b1);
      drain();
      chk("post_rst_beats", beats - b0, 2);
      chk("post_rst_err", err_cnt, exp_err);

      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fft_input_packer.md
Name: fft_input_packer

Overview:
- Front end of the 32-point pipelined FFT. Sits directly upstream of the first radix-2 butterfly/twiddle stage.
- Accepts a serial complex sample stream, one sample per cycle, with a valid/ready handshake.
- Packs each 32-sample frame into two 16-lane vector beats, beat 0 = x[0..15] and beat 1 = x[16..31]. The two beats are presented on consecutive cycles with valid held high, which is the contiguous-beat form the butterfly stage requires.
- Uses ping-pong double buffering so input can keep streaming while the previous frame drains.

Parameters:
- WIDTH, 12, bit width of each signed real/imag component, in and out.
- NUM, 16, output lanes per beat.
- DATA, 32, samples per frame. Must equal 2*NUM.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- s_valid  in  1  input sample valid
- s_ready  out  1  packer can accept a sample
- s_re  in  WIDTH signed  input real part
- s_im  in  WIDTH signed  input imaginary part
- s_last  in  1  marks the final sample of a frame
- dout_re  out  WIDTH signed x [0:NUM-1]  lane real outputs
- dout_im  out  WIDTH signed x [0:NUM-1]  lane imaginary outputs
- valid_out  out  1  beat valid; always high for exactly 2k consecutive cycles (k whole frames)
- frame_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset: all outputs are registered. dout_re/dout_im = 0, valid_out = 0, frame_err = 0, s_ready = 1. Both banks empty, write bank = 0, write index = 0, read FSM = IDLE. Reset asserted mid-frame discards all buffered data with no partial output.
- Handshake: a sample is accepted when s_valid && s_ready.
  - Accepted sample n (0..31) is written to bank[wb], beat n/NUM, lane n%NUM.
  - s_ready = 0 only while the current write bank is still full (both banks full). Data on s_re/s_im is ignored while s_ready = 0.
- Frame completion:
  - Acceptance of index 31 marks bank[wb] full, toggles wb and clears the index.
  - If s_last is not set on index 31, the frame is still completed and frame_err pulses on the next cycle.
  - If s_last is set on index ≠ 31, the partial frame is discarded: index is cleared, the bank stays empty, and frame_err pulses on the next cycle.
- Read FSM: IDLE -> BEAT0 -> BEAT1.
  - IDLE -> BEAT0 when bank[rb] is full.
  - BEAT0 drives beat 0 of bank[rb] with valid_out = 1.
  - BEAT1 drives beat 1 of bank[rb] with valid_out = 1, frees bank[rb] and toggles rb.
  - BEAT1 -> BEAT0 directly if the other bank is already full, giving back-to-back frames with no valid gap. Otherwise BEAT1 -> IDLE.
- Latency: if index 31 is accepted at cycle T and the reader is IDLE, beat 0 appears at T+1 and beat 1 at T+2.
- Outputs hold their last values when valid_out = 0. They do not return to zero.
- Simultaneous events: a bank freed in BEAT1 is writable in the same cycle. s_ready for the next cycle uses the post-free state, so s_ready never falls when only one frame is pending.
- Steady state is throughput-lossless. 32 input cycles per frame against 2 output cycles means s_ready stays high under continuous input.
- No arithmetic is performed; samples pass bit-exact.

Decomposition:
- Package fft_pkg:
  - constants FFT_N = 32, FFT_LANES = 16, FFT_IN_W = 12;
  - typedef cplx_t, a packed struct {re, im} of signed FFT_IN_W;
  - typedef lane_vec_t = cplx_t [0:FFT_LANES-1].
  - Shared by all FFT stages.
- Sub-module fft_pingpong_bank, instantiated twice:
  - one frame of storage, 2 beats x NUM lanes;
  - write port (en, index), full flag, read beat select, free strobe.
- The FSMs and bank select stay in the top.

Test Plan:
- Ramp: samples re = n, im = -n for n = 0..31, s_last on n = 31 -> at T+1, dout_re[i] = i and dout_im[i] = -i; at T+2, dout_re[i] = 16+i and dout_im[i] = -(16+i); valid_out high for exactly 2 cycles; frame_err never pulses.
- Three frames streamed continuously (value = 100*frame + n) -> s_ready stays 1 throughout; 3 pairs of beats with correct values; no frame lost.
- Backpressure: hold the reader path so both banks fill, via a force on the read FSM -> s_ready = 0; sample 64 is not accepted until a bank frees; on release, two frames are output back-to-back and valid_out stays high for 4 cycles.
- s_last on n = 9 -> frame_err pulses once, nothing is output; the next full 32-sample frame is output correctly starting from its own sample 0.
- s_last missing on n = 31 -> frame_err pulses once and the frame is still output.
- rstn asserted after 20 samples, then released -> all outputs 0, s_ready = 1; the following full frame is output with no remnant of the aborted one.
